// File: rtl/perf_pipeline_ctrl.sv
// Pipeline performance-counter controller: live event counters, outstanding-request
// latency integration, command-driven snapshot/restart and a registered snapshot read port.
module perf_pipeline_ctrl #(
    parameter int CTR_BITS  = 44,
    parameter int NUM_UNITS = 5,
    parameter int OCC_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 ibf_stall,
    input  logic                 scb_stall,
    input  logic [NUM_UNITS-1:0] unit_stall,
    input  logic                 ifetch_req,
    input  logic                 ifetch_rsp,
    input  logic                 load_req,
    input  logic                 load_rsp,
    input  logic                 store_req,
    input  logic                 cmd_valid,
    input  logic [1:0]           cmd_op,
    output logic                 cmd_ready,
    input  logic                 rd_req,
    input  logic [3:0]           rd_addr,
    output logic                 rd_rsp_valid,
    output logic [CTR_BITS-1:0]  rd_data
);

    localparam int NUM_CTRS   = NUM_UNITS + 7;
    localparam int IDX_IFETCH = NUM_UNITS + 2;
    localparam int IDX_LOAD   = NUM_UNITS + 3;
    localparam int IDX_STORE  = NUM_UNITS + 4;
    localparam int IDX_IF_LAT = NUM_UNITS + 5;
    localparam int IDX_LD_LAT = NUM_UNITS + 6;

    typedef enum logic {
        ST_IDLE,
        ST_SETTLE
    } state_e;

    state_e                state_q, state_d;
    logic [CTR_BITS-1:0]   live_q   [NUM_CTRS];
    logic [CTR_BITS-1:0]   live_d   [NUM_CTRS];
    logic [CTR_BITS-1:0]   shadow_q [NUM_CTRS];
    logic [CTR_BITS-1:0]   shadow_d [NUM_CTRS];
    logic [CTR_BITS-1:0]   inc      [NUM_CTRS];
    logic [OCC_BITS-1:0]   occ_if_q, occ_if_d;
    logic [OCC_BITS-1:0]   occ_ld_q, occ_ld_d;
    logic                  rd_rsp_valid_q, rd_rsp_valid_d;
    logic [CTR_BITS-1:0]   rd_data_q, rd_data_d;
    logic                  cmd_fire;

    // Saturating up/down tracker; simultaneous req and rsp cancel out.
    function automatic logic [OCC_BITS-1:0] occ_next(input logic [OCC_BITS-1:0] occ,
                                                    input logic req, input logic rsp);
        occ_next = occ;
        if (req && !rsp && occ != '1) begin
            occ_next = occ + 1'b1;
        end else if (rsp && !req && occ != '0) begin
            occ_next = occ - 1'b1;
        end
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d   = state_q;
        cmd_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = !reset;
                if (cmd_valid) state_d = ST_SETTLE;
            end
            ST_SETTLE: state_d = ST_IDLE;
        endcase
    end

    assign cmd_fire = cmd_valid && cmd_ready;

    always_comb begin
        for (int i = 0; i < NUM_CTRS; i++) inc[i] = '0;
        if (enable) begin
            inc[0] = CTR_BITS'(ibf_stall);
            inc[1] = CTR_BITS'(scb_stall);
            for (int u = 0; u < NUM_UNITS; u++) inc[2+u] = CTR_BITS'(unit_stall[u]);
            inc[IDX_IFETCH] = CTR_BITS'(ifetch_req);
            inc[IDX_LOAD]   = CTR_BITS'(load_req);
            inc[IDX_STORE]  = CTR_BITS'(store_req);
            inc[IDX_IF_LAT] = CTR_BITS'(occ_if_q);
            inc[IDX_LD_LAT] = CTR_BITS'(occ_ld_q);
        end
        // Capture takes the pre-increment value; restart keeps this cycle's events.
        for (int i = 0; i < NUM_CTRS; i++) begin
            shadow_d[i] = (cmd_fire && cmd_op[0]) ? live_q[i] : shadow_q[i];
            live_d[i]   = (cmd_fire && cmd_op[1]) ? inc[i] : live_q[i] + inc[i];
        end
        occ_if_d = occ_next(occ_if_q, ifetch_req, ifetch_rsp);
        occ_ld_d = occ_next(occ_ld_q, load_req, load_rsp);
    end

    // Reads see shadow_q before this edge's capture lands, so they return the old snapshot.
    always_comb begin
        rd_rsp_valid_d = rd_req;
        rd_data_d      = rd_data_q;
        if (rd_req) begin
            rd_data_d = '0;
            for (int i = 0; i < NUM_CTRS; i++) begin
                if (int'(rd_addr) == i) rd_data_d = shadow_q[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the counter arrays are architecturally visible and must read 0, so they are reset.
            state_q        <= ST_IDLE;
            live_q         <= '{default: '0};
            shadow_q       <= '{default: '0};
            occ_if_q       <= '0;
            occ_ld_q       <= '0;
            rd_rsp_valid_q <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            live_q         <= live_d;
            shadow_q       <= shadow_d;
            occ_if_q       <= occ_if_d;
            occ_ld_q       <= occ_ld_d;
            rd_rsp_valid_q <= rd_rsp_valid_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign rd_rsp_valid = rd_rsp_valid_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_perf_pipeline_ctrl.sv
// Self-checking bench for perf_pipeline_ctrl: directed scenarios plus a random phase,
// all compared every cycle against an event-counting reference model.
module tb_perf_pipeline_ctrl;

    localparam int NU   = 5;
    localparam int NC   = NU + 7;
    localparam int CB   = 44;
    localparam longint MASK = (64'd1 << CB) - 1;
    localparam int OCC_MAX = 255;

    logic          clk = 1'b0;
    logic          reset, enable, ibf_stall, scb_stall;
    logic [NU-1:0] unit_stall;
    logic          ifetch_req, ifetch_rsp, load_req, load_rsp, store_req;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic          cmd_ready;
    logic          rd_req;
    logic [3:0]    rd_addr;
    logic          rd_rsp_valid;
    logic [CB-1:0] rd_data;

    perf_pipeline_ctrl #(.CTR_BITS(CB), .NUM_UNITS(NU), .OCC_BITS(8)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .ibf_stall(ibf_stall), .scb_stall(scb_stall), .unit_stall(unit_stall),
        .ifetch_req(ifetch_req), .ifetch_rsp(ifetch_rsp),
        .load_req(load_req), .load_rsp(load_rsp), .store_req(store_req),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Reference model: plain event counts per counter index.
    longint     live_m [NC];
    longint     shadow_m [NC];
    int         occ_if_m, occ_ld_m;
    bit         busy_m;
    bit         exp_valid;
    longint     exp_data;
    int         checks = 0;
    int         failures = 0;

    function automatic int occ_upd(int occ, logic req, logic rsp);
        if (req && !rsp) return (occ < OCC_MAX) ? occ + 1 : OCC_MAX;
        if (rsp && !req) return (occ > 0) ? occ - 1 : 0;
        return occ;
    endfunction

    task automatic model_edge();
        longint inc [NC];
        bit     accepted;
        if (reset) begin
            for (int i = 0; i < NC; i++) begin live_m[i] = 0; shadow_m[i] = 0; end
            occ_if_m = 0; occ_ld_m = 0; busy_m = 0; exp_valid = 0; exp_data = 0;
            return;
        end
        accepted = cmd_valid && !busy_m;
        for (int i = 0; i < NC; i++) inc[i] = 0;
        if (enable) begin
            inc[0] = ibf_stall;
            inc[1] = scb_stall;
            for (int u = 0; u < NU; u++) inc[2+u] = unit_stall[u];
            inc[NU+2] = ifetch_req;
            inc[NU+3] = load_req;
            inc[NU+4] = store_req;
            inc[NU+5] = occ_if_m;
            inc[NU+6] = occ_ld_m;
        end
        exp_valid = rd_req;
        if (rd_req) exp_data = (int'(rd_addr) < NC) ? shadow_m[int'(rd_addr)] : 0;
        for (int i = 0; i < NC; i++) begin
            if (accepted && cmd_op[0]) shadow_m[i] = live_m[i];
            if (accepted && cmd_op[1]) live_m[i] = inc[i];
            else                       live_m[i] = (live_m[i] + inc[i]) & MASK;
        end
        occ_if_m = occ_upd(occ_if_m, ifetch_req, ifetch_rsp);
        occ_ld_m = occ_upd(occ_ld_m, load_req, load_rsp);
        busy_m   = accepted;
    endtask

    task automatic check_outputs();
        logic exp_ready;
        exp_ready = !reset && !busy_m;
        checks++;
        assert (cmd_ready === exp_ready) else begin
            failures++;
            $error("FAIL cmd_ready observed=%0b expected=%0b", cmd_ready, exp_ready);
        end
        checks++;
        assert (rd_rsp_valid === exp_valid) else begin
            failures++;
            $error("FAIL rd_rsp_valid observed=%0b expected=%0b", rd_rsp_valid, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            assert (rd_data === exp_data[CB-1:0]) else begin
                failures++;
                $error("FAIL rd_data observed=%0d expected=%0d", rd_data, exp_data[CB-1:0]);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic clear_strobes();
        ibf_stall = 0; scb_stall = 0; unit_stall = '0;
        ifetch_req = 0; ifetch_rsp = 0; load_req = 0; load_rsp = 0; store_req = 0;
    endtask

    // One accepted command followed by its settle cycle.
    task automatic command(logic [1:0] op);
        cmd_valid = 1; cmd_op = op;
        step();
        cmd_valid = 0;
        step();
    endtask

    task automatic read_expect(string tag, logic [3:0] addr, logic [CB-1:0] want);
        rd_req = 1; rd_addr = addr;
        step();
        rd_req = 0;
        checks++;
        assert (rd_rsp_valid === 1'b1 && rd_data === want) else begin
            failures++;
            $error("FAIL %s observed valid=%0b data=%0d expected valid=1 data=%0d",
                   tag, rd_rsp_valid, rd_data, want);
        end
    endtask

    initial begin
        reset = 1; enable = 0; cmd_valid = 0; cmd_op = 2'b00; rd_req = 0; rd_addr = '0;
        clear_strobes();

        // Reset state
        step(); step();
        checks++;
        assert (rd_data === '0 && rd_rsp_valid === 1'b0 && cmd_ready === 1'b0) else begin
            failures++;
            $error("FAIL reset_outputs observed data=%0d valid=%0b ready=%0b expected 0/0/0",
                   rd_data, rd_rsp_valid, cmd_ready);
        end
        reset = 0;
        #1;
        checks++;
        assert (cmd_ready === 1'b1) else begin
            failures++;
            $error("FAIL ready_after_reset observed=%0b expected=1", cmd_ready);
        end

        // Scoreboard stall count, capture, in-range and out-of-range read
        enable = 1; scb_stall = 1;
        repeat (10) step();
        scb_stall = 0;
        command(2'b01);
        read_expect("scb_count", 4'd1, 44'd10);
        read_expect("addr12_zero", 4'd12, 44'd0);

        // Fetch latency integration, including a response with nothing outstanding
        command(2'b11);
        for (int c = 0; c <= 10; c++) begin
            ifetch_req = (c <= 2);
            ifetch_rsp = (c >= 5 && c <= 7) || (c == 9);
            step();
        end
        clear_strobes();
        command(2'b01);
        read_expect("ifetch_count", 4'(NU + 2), 44'd3);
        rd_req = 1; rd_addr = 4'(NU + 5); step(); rd_req = 0;

        // Simultaneous load req/rsp with four outstanding
        command(2'b11);
        load_req = 1; repeat (4) step();
        load_rsp = 1; step();
        load_req = 0; load_rsp = 0; step();
        command(2'b01);
        read_expect("load_count", 4'(NU + 3), 44'd5);
        rd_req = 1; rd_addr = 4'(NU + 6); step(); rd_req = 0;
        load_rsp = 1; repeat (6) step(); load_rsp = 0;

        // Continuous ALU stall across capture+restart then capture
        unit_stall[2] = 1;
        cmd_valid = 1; cmd_op = 2'b11; step(); cmd_valid = 0;
        repeat (19) step();
        cmd_valid = 1; cmd_op = 2'b11; step(); cmd_valid = 0;
        read_expect("alu_first", 4'd4, 44'd20);
        repeat (8) step();
        cmd_valid = 1; cmd_op = 2'b01; rd_req = 1; rd_addr = 4'd4;
        step();
        cmd_valid = 0; rd_req = 0;
        checks++;
        assert (rd_data === 44'd20) else begin
            failures++;
            $error("FAIL read_during_capture observed=%0d expected=20", rd_data);
        end
        read_expect("alu_second", 4'd4, 44'd10);
        unit_stall = '0;

        // Counting disabled: counters hold, trackers still move; command handshake timing
        command(2'b11);
        enable = 0;
        ibf_stall = 1; scb_stall = 1; unit_stall = '1; ifetch_req = 1; store_req = 1;
        repeat (5) step();
        clear_strobes();
        enable = 1;
        cmd_valid = 1; cmd_op = 2'b01; step(); cmd_valid = 0;
        checks++;
        assert (cmd_ready === 1'b0) else begin
            failures++;
            $error("FAIL ready_settle observed=%0b expected=0", cmd_ready);
        end
        step();
        checks++;
        assert (cmd_ready === 1'b1) else begin
            failures++;
            $error("FAIL ready_return observed=%0b expected=1", cmd_ready);
        end
        read_expect("ibf_disabled", 4'd0, 44'd0);
        read_expect("store_disabled", 4'(NU + 4), 44'd0);
        ifetch_rsp = 1; repeat (6) step(); ifetch_rsp = 0;

        // Tracker saturation: 300 requests while disabled, then two counted cycles
        command(2'b11);
        enable = 0; ifetch_req = 1;
        repeat (300) step();
        ifetch_req = 0; enable = 1;
        repeat (2) step();
        command(2'b01);
        read_expect("occ_saturate", 4'(NU + 5), 44'd510);
        enable = 0; ifetch_rsp = 1; repeat (260) step(); ifetch_rsp = 0; enable = 1;

        // Reset during a read drops the response and clears everything
        rd_req = 1; rd_addr = 4'(NU + 5); reset = 1;
        step();
        rd_req = 0; reset = 0;
        checks++;
        assert (rd_rsp_valid === 1'b0) else begin
            failures++;
            $error("FAIL reset_drops_read observed=%0b expected=0", rd_rsp_valid);
        end
        command(2'b01);
        for (int a = 0; a < 16; a++) read_expect("post_reset_zero", 4'(a), 44'd0);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            reset      = ($urandom_range(0, 199) == 0);
            enable     = ($urandom_range(0, 7) != 0);
            ibf_stall  = $urandom_range(0, 1);
            scb_stall  = $urandom_range(0, 1);
            unit_stall = NU'($urandom);
            ifetch_req = ($urandom_range(0, 2) == 0);
            ifetch_rsp = ($urandom_range(0, 3) == 0);
            load_req   = ($urandom_range(0, 2) == 0);
            load_rsp   = ($urandom_range(0, 3) == 0);
            store_req  = $urandom_range(0, 1);
            cmd_valid  = ($urandom_range(0, 5) == 0);
            cmd_op     = 2'($urandom);
            rd_req     = $urandom_range(0, 1);
            rd_addr    = 4'($urandom);
            step();
        end
        reset = 0; cmd_valid = 0; rd_req = 0;
        clear_strobes();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
